// File: rtl/pre_adder_sub_pipe.sv
// Pipelined D+B / D-B / bypass-B pre-adder with a carry/borrow flag, optional input and output stages and a valid pipeline.
// Define PRE_ADDER_SAT_EN to saturate the result on carry/borrow instead of wrapping.
module pre_adder_sub_pipe #(
  parameter int WIDTH   = 18,
  parameter int IN_REG  = 1,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_in,
  input  logic             ce_out,
  input  logic             in_valid,
  input  logic             opmode6,
  input  logic             opmode4,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry
);

  logic [WIDTH-1:0] d_s, b_s;
  logic             op6_s, op4_s, vld_raw, vld_s;

  generate
    if (IN_REG != 0) begin : g_in
      logic [WIDTH-1:0] d_q, b_q;
      logic             op6_q, op4_q, vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q   <= '0;
          b_q   <= '0;
          op6_q <= 1'b0;
          op4_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (ce_in) begin
          d_q   <= d;
          b_q   <= b;
          op6_q <= opmode6;
          op4_q <= opmode4;
          vld_q <= in_valid;
        end
      end
      assign d_s     = d_q;
      assign b_s     = b_q;
      assign op6_s   = op6_q;
      assign op4_s   = op4_q;
      assign vld_raw = vld_q;
    end else begin : g_in_wire
      assign d_s     = d;
      assign b_s     = b;
      assign op6_s   = opmode6;
      assign op4_s   = opmode4;
      assign vld_raw = in_valid;
    end
  endgenerate

  // A held input beat already taken by the output stage must not be taken again
  // while ce_in stays low; the flag clears on the next input-stage update.
  logic cons_q, cons_d;

  always_comb begin
    cons_d = cons_q;
    if (IN_REG == 0 || OUT_REG == 0) cons_d = 1'b0;
    else if (ce_in)                  cons_d = 1'b0;
    else if (ce_out && vld_raw)      cons_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cons_q <= 1'b0;
    else     cons_q <= cons_d;
  end

  assign vld_s = vld_raw & ~cons_q;

  // Zero-extended WIDTH+1 arithmetic: the top bit is carry on add, borrow on sub.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             cy_d;

  always_comb begin
    sum   = '0;
    res_d = b_s;
    cy_d  = 1'b0;
    if (op4_s) begin
      sum   = op6_s ? ({1'b0, d_s} - {1'b0, b_s}) : ({1'b0, d_s} + {1'b0, b_s});
      res_d = sum[WIDTH-1:0];
      cy_d  = sum[WIDTH];
`ifdef PRE_ADDER_SAT_EN
      if (cy_d) res_d = op6_s ? '0 : '1;
`endif
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out
      logic [WIDTH-1:0] out_q;
      logic             carry_q, vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q   <= '0;
          carry_q <= 1'b0;
          vld_q   <= 1'b0;
        end else if (ce_out) begin
          out_q   <= res_d;
          carry_q <= cy_d;
          vld_q   <= vld_s;
        end
      end
      assign out       = out_q;
      assign carry     = carry_q;
      assign out_valid = vld_q;
    end else begin : g_out_wire
      assign out       = res_d;
      assign carry     = cy_d;
      assign out_valid = vld_s;
    end
  endgenerate

endmodule

// File: tb/tb_pre_adder_sub_pipe.sv
// Scoreboard bench: a 2-stage 18-bit instance under directed enable/reset traffic, plus
// W=2/L=0, W=48/in-reg-only and W=18/out-reg-only instances under a mixed sweep.
module tb_pre_adder_sub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce_in, ce_out, in_valid, x_valid, op6, op4;
  logic [47:0] d, b;
  logic [17:0] m_out;  logic m_v, m_c;
  logic [1:0]  a_out;  logic a_v, a_c;
  logic [47:0] w_out;  logic w_v, w_c;
  logic [17:0] o_out;  logic o_v, o_c;

  int   checks = 0, errors = 0, cyc = 0;
  logic upd = 1'b0;

  typedef struct { logic [47:0] r; logic c; int t; } exp_t;
  exp_t q_m[$], q_a[$], q_w[$], q_o[$];
  exp_t e_m, e_a, e_w, e_o, last_m;

`ifdef PRE_ADDER_SAT_EN
  localparam logic [47:0] OVF_ADD  = 48'h3FFFF;
  localparam logic [47:0] UNF_SUB  = 48'h0;
  localparam logic [47:0] FULL_ADD = 48'h3FFFF;
`else
  localparam logic [47:0] OVF_ADD  = 48'h0;
  localparam logic [47:0] UNF_SUB  = 48'h3FFFF;
  localparam logic [47:0] FULL_ADD = 48'h3FFFE;
`endif

  pre_adder_sub_pipe #(.WIDTH(18), .IN_REG(1), .OUT_REG(1)) u_main (
    .clk(clk), .rst(rst), .ce_in(ce_in), .ce_out(ce_out), .in_valid(in_valid),
    .opmode6(op6), .opmode4(op4), .d(d[17:0]), .b(b[17:0]),
    .out(m_out), .out_valid(m_v), .carry(m_c));
  pre_adder_sub_pipe #(.WIDTH(2), .IN_REG(0), .OUT_REG(0)) u_w2 (
    .clk(clk), .rst(rst), .ce_in(1'b1), .ce_out(1'b1), .in_valid(x_valid),
    .opmode6(op6), .opmode4(op4), .d(d[1:0]), .b(b[1:0]),
    .out(a_out), .out_valid(a_v), .carry(a_c));
  pre_adder_sub_pipe #(.WIDTH(48), .IN_REG(1), .OUT_REG(0)) u_w48 (
    .clk(clk), .rst(rst), .ce_in(1'b1), .ce_out(1'b1), .in_valid(x_valid),
    .opmode6(op6), .opmode4(op4), .d(d), .b(b),
    .out(w_out), .out_valid(w_v), .carry(w_c));
  pre_adder_sub_pipe #(.WIDTH(18), .IN_REG(0), .OUT_REG(1)) u_o18 (
    .clk(clk), .rst(rst), .ce_in(1'b1), .ce_out(1'b1), .in_valid(x_valid),
    .opmode6(op6), .opmode4(op4), .d(d[17:0]), .b(b[17:0]),
    .out(o_out), .out_valid(o_v), .carry(o_c));

  function automatic exp_t model(input int w, input logic [47:0] dd, input logic [47:0] bb,
                                 input logic o6, input logic o4);
    exp_t e;
    logic [48:0] m, s, da, ba;
    m  = (49'd1 << w) - 49'd1;
    da = {1'b0, dd} & m;
    ba = {1'b0, bb} & m;
    e.t = cyc;
    if (!o4) begin
      e.r = ba[47:0];
      e.c = 1'b0;
    end else begin
      s   = o6 ? (da - ba) : (da + ba);
      e.c = o6 ? (da < ba) : s[w];
      s   = s & m;
      e.r = s[47:0];
`ifdef PRE_ADDER_SAT_EN
      if (e.c) e.r = o6 ? 48'h0 : m[47:0];
`endif
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [47:0] got, input logic gc,
                     input logic [47:0] er, input logic ec);
    checks++;
    if (got !== er || gc !== ec) begin
      errors++;
      $display("FAIL %s: out=%h carry=%b, expected out=%h carry=%b", nm, got, gc, er, ec);
    end
  endtask

  task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: out_valid with empty scoreboard", nm);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    upd <= ce_out;
  end

  // Main instance: a new result appears only after an output-stage update; otherwise it must hold.
  always @(negedge clk) begin
    if (m_v) begin
      if (upd) begin
        if (q_m.size() == 0) unexpected("main");
        else begin
          e_m = q_m.pop_front();
          cmp("main", {30'b0, m_out}, m_c, e_m.r, e_m.c);
          last_m = e_m;
        end
      end else cmp("main_hold", {30'b0, m_out}, m_c, last_m.r, last_m.c);
    end
  end

  always @(negedge clk) begin
    if (a_v) begin
      if (q_a.size() == 0) unexpected("w2_l0");
      else begin
        e_a = q_a.pop_front();
        cmp("w2_l0", {46'b0, a_out}, a_c, e_a.r, e_a.c);
        chk("w2_l0_latency", 48'(cyc - e_a.t), 48'd0);
      end
    end
    if (w_v) begin
      if (q_w.size() == 0) unexpected("w48_in");
      else begin
        e_w = q_w.pop_front();
        cmp("w48_in", w_out, w_c, e_w.r, e_w.c);
        chk("w48_in_latency", 48'(cyc - e_w.t), 48'd1);
      end
    end
    if (o_v) begin
      if (q_o.size() == 0) unexpected("w18_out");
      else begin
        e_o = q_o.pop_front();
        cmp("w18_out", {30'b0, o_out}, o_c, e_o.r, e_o.c);
        chk("w18_out_latency", 48'(cyc - e_o.t), 48'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [47:0] dd, input logic [47:0] bb, input logic o6, input logic o4);
    d = dd; b = bb; op6 = o6; op4 = o4;
  endtask

  task automatic issue(input logic [47:0] dd, input logic [47:0] bb, input logic o6, input logic o4,
                       input logic [47:0] er, input logic ec);
    step();
    drive(dd, bb, o6, o4);
    in_valid = 1'b1;
    q_m.push_back('{r: er, c: ec, t: cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      in_valid = 1'b0;
      x_valid  = 1'b0;
    end
  endtask

  task automatic sweep(input logic [47:0] dd, input logic [47:0] bb, input logic o6, input logic o4);
    step();
    drive(dd, bb, o6, o4);
    x_valid = 1'b1;
    q_a.push_back(model(2, dd, bb, o6, o4));
    q_w.push_back(model(48, dd, bb, o6, o4));
    q_o.push_back(model(18, dd, bb, o6, o4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd, rb;
    rst = 1'b1; ce_in = 1'b1; ce_out = 1'b1; in_valid = 1'b0; x_valid = 1'b0;
    op6 = 1'b0; op4 = 1'b0; d = '0; b = '0;
    repeat (3) step();
    @(negedge clk);
    cmp("reset_main", {30'b0, m_out}, m_c, 48'h0, 1'b0);
    chk("reset_main_valid", 48'(m_v), 48'd0);
    cmp("reset_w18_out", {30'b0, o_out}, o_c, 48'h0, 1'b0);
    chk("reset_w48_valid", 48'(w_v), 48'd0);
    step();
    rst = 1'b0;

    // First beat: 5-3 must surface exactly two edges after issue.
    issue(48'd5, 48'd3, 1'b1, 1'b1, 48'd2, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_1_valid", 48'(m_v), 48'd0);
    step();
    @(negedge clk);
    chk("latency_2_valid", 48'(m_v), 48'd1);
    chk("latency_2_out", {30'b0, m_out}, 48'd2);
    idle(3);

    // Overflow, borrow, bypass then add back-to-back, boundaries.
    issue(48'h3FFFF, 48'd1,     1'b0, 1'b1, OVF_ADD,   1'b1);
    issue(48'd0,     48'd1,     1'b1, 1'b1, UNF_SUB,   1'b1);
    issue(48'd7,     48'd9,     1'b0, 1'b0, 48'd9,     1'b0);
    issue(48'd7,     48'd9,     1'b0, 1'b1, 48'd16,    1'b0);
    issue(48'd100,   48'd100,   1'b1, 1'b1, 48'd0,     1'b0);
    issue(48'h20000, 48'h20000, 1'b0, 1'b1, OVF_ADD,   1'b1);
    issue(48'd1,     48'h3FFFF, 1'b1, 1'b0, 48'h3FFFF, 1'b0);
    idle(4);

    // Both stages stalled three edges mid-stream.
    issue(48'd10, 48'd4, 1'b0, 1'b1, 48'd14,  1'b0);
    issue(48'd10, 48'd4, 1'b1, 1'b1, 48'd6,   1'b0);
    issue(48'd1,  48'd2, 1'b1, 1'b1, UNF_SUB, 1'b1);
    step();
    ce_in = 1'b0; ce_out = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    ce_in = 1'b1; ce_out = 1'b1;
    idle(4);

    // Input stage held while the output keeps sampling: the beat must appear once.
    issue(48'd20, 48'd22, 1'b0, 1'b1, 48'd42, 1'b0);
    step();
    ce_in = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    ce_in = 1'b1;
    idle(4);

    // Reset with one beat registered and one presented alongside rst: both are lost.
    step();
    drive(48'd1, 48'd1, 1'b0, 1'b1);
    in_valid = 1'b1;
    step();
    drive(48'd2, 48'd2, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("midrst_out", {30'b0, m_out}, m_c, 48'h0, 1'b0);
    chk("midrst_valid", 48'(m_v), 48'd0);
    step();
    @(negedge clk);
    chk("midrst_valid_1", 48'(m_v), 48'd0);
    step();
    @(negedge clk);
    chk("midrst_valid_2", 48'(m_v), 48'd0);
    issue(48'h3FFFF, 48'h3FFFF, 1'b0, 1'b1, FULL_ADD, 1'b1);
    idle(4);

    // Width/latency sweep over the other three instances.
    sweep(48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b1);
    sweep(48'd0,              48'd1, 1'b1, 1'b1);
    sweep(48'd3,              48'd3, 1'b0, 1'b1);
    sweep(48'd2,              48'd1, 1'b1, 1'b1);
    sweep(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b0, 1'b1);
    sweep(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b1, 1'b1);
    sweep(48'd5,              48'd7, 1'b1, 1'b0);
    sweep(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      sweep(rd[47:0], rb[47:0], 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    idle(5);

    chk("drain_main", 48'(q_m.size()), 48'd0);
    chk("drain_w2",   48'(q_a.size()), 48'd0);
    chk("drain_w48",  48'(q_w.size()), 48'd0);
    chk("drain_w18",  48'(q_o.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pre_adder_sub_pipe.md
Name: pre_adder_sub_pipe

Overview:
- Parametrised, pipelined successor of the DSP48A1 pre-adder/subtractor.
- Computes d+b, d-b or bypass-b at WIDTH bits, with optional input and output register stages, per-stage clock enables, a valid pipeline and a carry/borrow flag.
- Sits between the D/B input registers and the multiplier A/B path of the DSP48A1 slice model.

Parameters:
WIDTH, 18, operand and result width in bits (unsigned), legal range 2..48
IN_REG, 1, 0 = d/b/mode inputs combinational into adder; 1 = one register stage (DREG/BREG equivalent)
OUT_REG, 1, 0 = result combinational from adder; 1 = one output register stage (B1REG equivalent)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
ce_in  input  1  clock enable for input stage (d, b, opmode, in_valid)
ce_out  input  1  clock enable for output stage
in_valid  input  1  qualifies d, b, opmode6, opmode4 this cycle
opmode6  input  1  1 = subtract (d-b), 0 = add (d+b)
opmode4  input  1  1 = use pre-adder result, 0 = bypass (out = b)
d  input  WIDTH  pre-adder D operand
b  input  WIDTH  pre-adder B operand
out  output  WIDTH  result
out_valid  output  1  out holds a valid result
carry  output  1  unsigned carry-out (add) or borrow (sub); 0 in bypass

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high. rst has priority over both clock enables.
- Reset values: out = 0, carry = 0, out_valid = 0. All internal stage registers also clear to 0.
- Arithmetic:
  - Computed at WIDTH+1 bits. Add: {carry,out} = d + b. Sub: {borrow,out} = d - b, where borrow = 1 iff d < b.
  - out wraps modulo 2^WIDTH.
  - Bypass (opmode4 = 0): out = b, carry = 0, opmode6 ignored.
- Input stage (IN_REG = 1):
  - On a clk edge with ce_in = 1, register d, b, opmode6, opmode4 and in_valid.
  - With ce_in = 0, hold all of them, including the stored valid.
  - The mode bits are registered with the operands, so a mode change never mixes with older operands.
- Output stage (OUT_REG = 1):
  - On a clk edge with ce_out = 1, register out, carry and the stage valid.
  - With ce_out = 0, hold them.
- Pass-through stages: IN_REG = 0 or OUT_REG = 0 makes that stage a wire, and its ce is ignored.
- Latency L = IN_REG + OUT_REG cycles from in_valid to out_valid, with both ce = 1.
  - L = 0 is fully combinational; out_valid = in_valid.
- Valid rules:
  - out_valid follows in_valid through the same stages and enables.
  - No backpressure.
  - A stage whose ce is low keeps its data and valid. Data is never duplicated or dropped except by rst.
- Invalid beats: data with in_valid = 0 still propagates, but out_valid = 0 for it. Checkers must ignore out/carry when out_valid = 0.
- Reset mid-operation: rst for one cycle clears every in-flight result. out_valid is 0 on the following cycle and stays 0 until a new in_valid beat reaches the output after L cycles.
- Simultaneous events:
  - rst = 1 with ce = 1 and in_valid = 1: reset wins and the beat is lost.
  - ce_in = 0 with ce_out = 1: the output stage re-captures the held input stage.
    - Its valid bit is re-captured too, so one input beat can appear on consecutive cycles.
    - To prevent this, the output stage clears the stored input valid once consumed: a valid input-stage beat captured by the output stage is marked consumed until the next ce_in edge.

Optional Feature:
- Macro PRE_ADDER_SAT_EN.
- When defined, out saturates instead of wrapping:
  - add with carry → out = 2^WIDTH-1
  - sub with borrow → out = 0
  - carry still reports the event.
- When undefined, out wraps modulo 2^WIDTH as above. Latency is identical in both builds.

Test Plan:
- Default params, ce = 1: d=5, b=3, opmode6=1, opmode4=1, in_valid=1 → 2 cycles later out=2, carry=0, out_valid=1.
- Add overflow: d=18'h3FFFF, b=1, opmode6=0 → out=0, carry=1. With PRE_ADDER_SAT_EN: out=18'h3FFFF, carry=1.
- Sub borrow: d=0, b=1, opmode6=1 → out=18'h3FFFF, carry=1. With PRE_ADDER_SAT_EN: out=0, carry=1.
- Bypass and back-to-back: stream (d=7,b=9,opmode4=0), then (d=7,b=9,opmode4=1,opmode6=0) on consecutive cycles → out=9, carry=0, then out=16 on consecutive cycles.
- Enables and reset:
  - ce_out=0 for 3 cycles mid-stream → out/out_valid held, then resumes with no loss or duplication.
  - rst pulsed with 2 beats in flight → out=0 and out_valid=0 the next cycle; no stale beat emerges.
- Parameter sweep: IN_REG/OUT_REG ∈ {0,1}², WIDTH ∈ {2, 18, 48} with random d/b/modes against a reference model → latency equals IN_REG+OUT_REG, all results match.
